// File: rtl/hazard_tnew_ctrl.sv
// Tuse/Tnew hazard and bypass controller for the F/D/E/M/W pipeline.
// Optional MDU busy interlock is built when HAZARD_MDU_EN is defined.
module hazard_tnew_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [1:0]        d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic              md_busy
);

  logic [REG_AW-1:0] e_rs_q, e_rs_d;
  logic [REG_AW-1:0] e_rt_q, e_rt_d;
  logic [REG_AW-1:0] e_dst_q, e_dst_d;
  logic [1:0]        e_tnew_q, e_tnew_d;
  logic [REG_AW-1:0] m_rt_q, m_rt_d;
  logic [REG_AW-1:0] m_dst_q, m_dst_d;
  logic [1:0]        m_tnew_q, m_tnew_d;
  logic [REG_AW-1:0] w_dst_q, w_dst_d;
  logic              rs_hz, rt_hz;

  // D-side select: nearest matching stage wins, stale data gives RF
  function automatic logic [1:0] sel_d(
    input logic [REG_AW-1:0] a,
    input logic [REG_AW-1:0] ed,
    input logic [1:0]        et,
    input logic [REG_AW-1:0] md,
    input logic [1:0]        mt
  );
    logic [1:0] s;
    s = 2'd0;
    if (a == '0)    s = 2'd0;
    else if (ed == a) s = (et == 2'd0) ? 2'd1 : 2'd0;
    else if (md == a) s = (mt == 2'd0) ? 2'd2 : 2'd0;
    return s;
  endfunction

  // E-side select: M before W; W is always ready
  function automatic logic [1:0] sel_e(
    input logic [REG_AW-1:0] a,
    input logic [REG_AW-1:0] md,
    input logic [1:0]        mt,
    input logic [REG_AW-1:0] wd
  );
    logic [1:0] s;
    s = 2'd0;
    if (a == '0)    s = 2'd0;
    else if (md == a) s = (mt == 2'd0) ? 2'd1 : 2'd0;
    else if (wd == a) s = 2'd2;
    return s;
  endfunction

  // register hazards: producer in E or M not ready by the use time
  always_comb begin
    rs_hz = (d_rs != '0) && (d_tuse_rs != 2'd3) &&
            (((e_dst_q == d_rs) && (e_tnew_q > d_tuse_rs)) ||
             ((m_dst_q == d_rs) && (m_tnew_q > d_tuse_rs)));
    rt_hz = (d_rt != '0) && (d_tuse_rt != 2'd3) &&
            (((e_dst_q == d_rt) && (e_tnew_q > d_tuse_rt)) ||
             ((m_dst_q == d_rt) && (m_tnew_q > d_tuse_rt)));
  end

  // bypass mux selects
  always_comb begin
    fwd_rs_d = sel_d(d_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    fwd_rt_d = sel_d(d_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    fwd_rs_e = sel_e(e_rs_q, m_dst_q, m_tnew_q, w_dst_q);
    fwd_rt_e = sel_e(e_rt_q, m_dst_q, m_tnew_q, w_dst_q);
    fwd_rt_m = (m_rt_q != '0) && (w_dst_q == m_rt_q);
  end

  // shadow pipeline advance; a stall pushes a bubble into E
  always_comb begin
    e_rs_d   = d_rs;
    e_rt_d   = d_rt;
    e_dst_d  = d_dst;
    e_tnew_d = d_tnew;
    if (stall) begin
      e_rs_d   = '0;
      e_rt_d   = '0;
      e_dst_d  = '0;
      e_tnew_d = 2'd0;
    end
    m_rt_d   = e_rt_q;
    m_dst_d  = e_dst_q;
    m_tnew_d = (e_tnew_q != 2'd0) ? e_tnew_q - 2'd1 : 2'd0;
    w_dst_d  = m_dst_q;
  end

  // shadow registers
  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_dst_q  <= '0;
      e_tnew_q <= 2'd0;
      m_rt_q   <= '0;
      m_dst_q  <= '0;
      m_tnew_q <= 2'd0;
      w_dst_q  <= '0;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      m_rt_q   <= m_rt_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
    end
  end

`ifdef HAZARD_MDU_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // busy counter: load on an issued start, else count down
  always_comb begin
    cnt_d = cnt_q;
    if (d_md_start && !stall)
      cnt_d = d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  // busy counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign md_busy = (cnt_q != '0);
  assign stall   = rs_hz | rt_hz | (d_md_use & md_busy);
`else
  logic unused_md;
  assign unused_md = ^{d_md_start, d_md_div, d_md_use};
  assign md_busy   = 1'b0;
  assign stall     = rs_hz | rt_hz;
`endif

endmodule

// File: tb/tb_hazard_tnew_ctrl.sv
// Bench for hazard_tnew_ctrl: age-based pipeline model plus
// directed instruction sequences with literal expectations.
module tb_hazard_tnew_ctrl;

`ifdef HAZARD_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif
  localparam int NDIV = 10;
  localparam int NMUL = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, fwd_rt_m, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int total = 0;
  int bad   = 0;

  hazard_tnew_ctrl #(
    .REG_AW(5), .MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_use(d_md_use),
    .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // model: instructions in flight indexed by age (0=E,1=M,2=W);
  // result ready once age >= tnew
  typedef struct {
    int rs; int rt; int dst; int tnew;
  } rec_t;
  rec_t st [3];
  int   cyc = 0;
  int   md_until = 0;
  bit   chk_en = 1'b0;

  function automatic int left(input int age);
    int r;
    r = st[age].tnew - age;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit hz(input int a, input int tu);
    if (a == 0 || tu == 3) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (st[k].dst == a && left(k) > tu) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    return MDU && (cyc <= md_until);
  endfunction

  function automatic bit m_stall();
    return hz(int'(d_rs), int'(d_tuse_rs)) ||
           hz(int'(d_rt), int'(d_tuse_rt)) ||
           (d_md_use && m_busy());
  endfunction

  // nearest producer among ages lo..2; select = base+age if ready
  function automatic int m_fwd(input int a, input int lo);
    if (a == 0) return 0;
    for (int k = lo; k < 3; k++)
      if (st[k].dst == a) return (left(k) == 0) ? k - lo + 1 : 0;
    return 0;
  endfunction

  // model state advance
  always @(posedge clk) begin
    bit s;
    s = m_stall();
    cyc = cyc + 1;
    if (reset) begin
      for (int k = 0; k < 3; k++) st[k] = '{0, 0, 0, 0};
      md_until = 0;
      chk_en = 1'b1;
    end else begin
      if (d_md_start && !s)
        md_until = cyc + (d_md_div ? NDIV : NMUL) - 1;
      st[2] = st[1];
      st[1] = st[0];
      if (s) st[0] = '{0, 0, 0, 0};
      else   st[0] = '{int'(d_rs), int'(d_rt), int'(d_dst), int'(d_tnew)};
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int m_fd;
      chk("stall", stall, m_stall());
      chk("md_busy", md_busy, m_busy());
      m_fd = (d_rs == 0) ? 0 :
             (st[0].dst == d_rs) ? ((left(0) == 0) ? 1 : 0) :
             (st[1].dst == d_rs) ? ((left(1) == 0) ? 2 : 0) : 0;
      chk("fwd_rs_d", fwd_rs_d, m_fd);
      m_fd = (d_rt == 0) ? 0 :
             (st[0].dst == d_rt) ? ((left(0) == 0) ? 1 : 0) :
             (st[1].dst == d_rt) ? ((left(1) == 0) ? 2 : 0) : 0;
      chk("fwd_rt_d", fwd_rt_d, m_fd);
      chk("fwd_rs_e", fwd_rs_e, m_fwd(st[0].rs, 1));
      chk("fwd_rt_e", fwd_rt_e, m_fwd(st[0].rt, 1));
      chk("fwd_rt_m", fwd_rt_m,
          (st[1].rt != 0) && (st[2].dst == st[1].rt));
    end
  end

  task automatic drv(input int rs, input int rt, input int urs,
                     input int urt, input int dst, input int tn,
                     input bit ms, input bit md, input bit mu);
    d_rs = 5'(rs);  d_rt = 5'(rt);
    d_tuse_rs = 2'(urs);  d_tuse_rt = 2'(urt);
    d_dst = 5'(dst);  d_tnew = 2'(tn);
    d_md_start = ms;  d_md_div = md;  d_md_use = mu;
  endtask

  task automatic nop();
    drv(0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // call at a negedge; returns at the first negedge without stall
  task automatic hold(output int n);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      bad++;
      total++;
      $display("FAIL stall_timeout got=%0d exp=<40", n);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    drv(5, 0, 0, 3, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_fwd", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}, 0);
    tick();
    reset = 1'b0;

    // ALU chain on $3
    drv(1, 2, 1, 1, 3, 1, 0, 0, 0);
    @(negedge clk); hold(n); tick();
    drv(3, 2, 1, 1, 7, 1, 0, 0, 0);
    @(negedge clk);
    chk("alu_stall", stall, 0);
    hold(n); tick();
    drv(3, 0, 1, 3, 8, 1, 0, 0, 0);
    @(negedge clk);
    chk("alu_e_m", fwd_rs_e, 1);
    chk("alu_d_m", fwd_rs_d, 2);
    hold(n); tick();
    nop();
    @(negedge clk);
    chk("alu_e_w", fwd_rs_e, 2);
    tick();

    // load then branch
    drv(1, 0, 1, 3, 4, 2, 0, 0, 0);
    @(negedge clk); hold(n);
    chk("lw_nostall", n, 0);
    tick();
    drv(4, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lb_stall", stall, 1);
    hold(n);
    chk("lb_cycles", n, 2);
    chk("lb_fwd_d", fwd_rs_d, 0);
    tick();

    // load then ALU use
    drv(1, 0, 1, 3, 5, 2, 0, 0, 0);
    @(negedge clk); hold(n); tick();
    drv(5, 0, 1, 3, 0, 1, 0, 0, 0);
    @(negedge clk); hold(n);
    chk("lu_cycles", n, 1);
    tick();
    nop();
    @(negedge clk);
    chk("lu_fwd_e", fwd_rs_e, 2);
    tick();

    // jal -> jr
    drv(0, 0, 3, 3, 31, 0, 0, 0, 0);
    @(negedge clk); hold(n); tick();
    drv(31, 0, 0, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("jr_stall", stall, 0);
    chk("jr_fwd_e", fwd_rs_d, 1);
    tick();
    drv(0, 0, 3, 3, 31, 0, 0, 0, 0);
    @(negedge clk); tick();
    nop();
    @(negedge clk); tick();
    drv(31, 0, 0, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("jr_fwd_m", fwd_rs_d, 2);
    tick();

    // store data after load
    drv(1, 0, 1, 3, 6, 2, 0, 0, 0);
    @(negedge clk); hold(n); tick();
    drv(1, 6, 1, 2, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sw_stall", stall, 0);
    tick();
    nop();
    @(negedge clk);
    chk("sw_fwd_e", fwd_rt_e, 0);
    tick();
    nop();
    @(negedge clk);
    chk("sw_fwd_m", fwd_rt_m, 1);
    tick();

    // register zero never stalls or forwards
    drv(1, 0, 1, 3, 0, 2, 0, 0, 0);
    @(negedge clk); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("r0_stall", stall, 0);
    chk("r0_fwd", fwd_rs_d, 0);
    tick();

    // E and M both match: E wins while not ready
    drv(1, 0, 1, 3, 9, 1, 0, 0, 0);
    @(negedge clk); tick();
    drv(1, 0, 1, 3, 9, 2, 0, 0, 0);
    @(negedge clk); tick();
    drv(9, 0, 3, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("em_stall", stall, 0);
    chk("em_e_wins", fwd_rs_d, 0);
    tick();
    nop();
    @(negedge clk); tick();

    // div then mfhi
    drv(1, 2, 1, 1, 0, 0, 1, 1, 1);
    @(negedge clk); hold(n);
    chk("div_issue", n, 0);
    tick();
    drv(0, 0, 3, 3, 10, 1, 0, 0, 1);
    @(negedge clk);
    chk("mfhi_busy", md_busy, MDU);
    hold(n);
    chk("mfhi_cycles", n, MDU ? NDIV : 0);
    chk("mfhi_idle", md_busy, 0);
    tick();

    // reset in the middle of a count
    drv(1, 2, 1, 1, 0, 0, 1, 1, 1);
    @(negedge clk); hold(n); tick();
    drv(0, 0, 3, 3, 10, 1, 0, 0, 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
    end
    chk("mid_busy", md_busy, MDU);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_busy", md_busy, 0);
    chk("mid_rst_stall", stall, 0);
    tick();
    reset = 1'b0;
    nop();
    @(negedge clk);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
